// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw switch vector in, debounced value and change flag out.
interface sw_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] SW;
    logic             chg_ack;
    logic [WIDTH-1:0] sw_stable;
    logic             sw_chg;

    modport master (output SW, output chg_ack, input sw_stable, input sw_chg);
    modport slave  (input SW, input chg_ack, output sw_stable, output sw_chg);
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus whole-vector debouncer for the board slide switches.
// Optional macro SW_DEBOUNCE_STICKY_EN makes sw_chg sticky until chg_ack.
//
// state  | meaning
// IDLE   | candidate equals committed value, nothing pending
// SETTLE | new candidate differs from sw_stable, counting stable cycles
module sw_debounce #(
    parameter int WIDTH     = 10,
    parameter int DB_CYCLES = 1000000
) (
    input logic         clk,
    input logic         rst,
    sw_debounce_if.slave bus
);
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             chg_q, chg_d;
    logic             commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus.SW;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
        end
    end

    // Any change of the synchronized vector restarts the settle window.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = (sync2_q == stable_q) ? IDLE : SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_MAX) begin
                commit  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        stable_d = commit ? cand_q : stable_q;
`ifdef SW_DEBOUNCE_STICKY_EN
        // Set has priority over acknowledge on the same edge.
        chg_d = commit | (chg_q & ~bus.chg_ack);
`else
        chg_d = commit;
`endif
    end

`ifndef SW_DEBOUNCE_STICKY_EN
    logic chg_ack_unused;
    assign chg_ack_unused = bus.chg_ack;
`endif

    assign bus.sw_stable = stable_q;
    assign bus.sw_chg    = chg_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Randomized and directed bench for sw_debounce against a run-length reference model.
module tb_sw_debounce;
    localparam int W  = 10;
    localparam int DB = 4;
`ifdef SW_DEBOUNCE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Reference: a commit happens when the synchronized value has been
    // unchanged for DB+1 consecutive edges and differs from the committed value.
    logic [W-1:0] m_s1, m_s2, m_run_val, m_stable;
    int           m_run_len;
    logic         m_chg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = 0;
            m_stable = '0; m_chg = 1'b0;
        end else begin
            bit commit;
            if (m_s2 == m_run_val) begin
                if (m_run_len < 1000) m_run_len++;
            end else begin
                m_run_val = m_s2;
                m_run_len = 1;
            end
            commit = (m_run_val != m_stable) && (m_run_len == DB + 1);
            if (commit) m_stable = m_run_val;
            m_chg = STICKY ? (commit | (m_chg & ~bus.chg_ack)) : commit;
            m_s2 = m_s1;
            m_s1 = bus.SW;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            vectors++;
            if (bus.sw_stable !== m_stable || bus.sw_chg !== m_chg) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t sw_stable=%h chg=%b expected sw_stable=%h chg=%b",
                         $time, bus.sw_stable, bus.sw_chg, m_stable, m_chg);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Literal expectations checked against both the DUT and the model.
    task automatic chk(input string name, input logic [W-1:0] exp_s, input logic exp_c);
        vectors++;
        if (bus.sw_stable !== exp_s || bus.sw_chg !== exp_c) begin
            miscompares++;
            $display("FAIL %s dut sw_stable=%h chg=%b expected sw_stable=%h chg=%b",
                     name, bus.sw_stable, bus.sw_chg, exp_s, exp_c);
        end
        vectors++;
        if (m_stable !== exp_s || m_chg !== exp_c) begin
            miscompares++;
            $display("FAIL %s_model model sw_stable=%h chg=%b expected sw_stable=%h chg=%b",
                     name, m_stable, m_chg, exp_s, exp_c);
        end
    endtask

    task automatic clear_chg(input logic [W-1:0] exp_s);
        bus.chg_ack = 1'b1;
        step();
        bus.chg_ack = 1'b0;
        chk("ack_clear", exp_s, 1'b0);
    endtask

    // Drive a new value and verify the exact commit edge.
    task automatic clean_change(input string name, input logic [W-1:0] old_v, input logic [W-1:0] new_v);
        bus.SW = new_v;
        for (int k = 1; k <= DB + 2; k++) begin
            step();
            chk(name, old_v, 1'b0);
        end
        step();
        chk(name, new_v, 1'b1);
        step();
        chk(name, new_v, STICKY);
        clear_chg(new_v);
    endtask

    initial begin
        int rises;
        logic prev_c;
        logic [W-1:0] cur;
        bus.SW = 10'h155;
        bus.chg_ack = 1'b0;
        rst = 1'b1;
        cmp_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("in_reset", '0, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= DB + 2; k++) begin
            step();
            chk("first_wait", '0, 1'b0);
        end
        step();
        chk("first_commit", 10'h155, 1'b1);
        step();
        chk("first_after", 10'h155, STICKY);
        clear_chg(10'h155);

        clean_change("clean", 10'h155, 10'h234);

        for (int i = 0; i < 10; i++) begin
            bus.SW = (i % 2 == 0) ? 10'h377 : 10'h234;
            step();
            chk("bounce", 10'h234, 1'b0);
            step();
            chk("bounce", 10'h234, 1'b0);
        end
        bus.SW = 10'h377;
        rises = 0;
        prev_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.sw_chg && !prev_c) rises++;
            prev_c = bus.sw_chg;
        end
        vectors++;
        if (rises != 1) begin
            miscompares++;
            $display("FAIL bounce_pulses got %0d expected 1", rises);
        end
        chk("bounce_final", 10'h377, STICKY);
        clear_chg(10'h377);

        bus.SW = 10'h000;
        step(3);
        bus.SW = 10'h377;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch", 10'h377, 1'b0);
        end

        bus.SW = 10'h0AA;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("pre_reset", 10'h377, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("async_reset", '0, 1'b0);
        step(2);
        chk("held_reset", '0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= DB + 2; k++) begin
            step();
            chk("post_reset_wait", '0, 1'b0);
        end
        step();
        chk("post_reset_commit", 10'h0AA, 1'b1);
        step();
        clear_chg(10'h0AA);

`ifdef SW_DEBOUNCE_STICKY_EN
        bus.SW = 10'h155;
        step(DB + 3);
        chk("sticky_commit", 10'h155, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sticky_hold", 10'h155, 1'b1);
        end
        clear_chg(10'h155);
        bus.SW = 10'h2C3;
        step(DB + 2);
        chk("sticky_pre", 10'h155, 1'b0);
        bus.chg_ack = 1'b1;
        step();
        bus.chg_ack = 1'b0;
        chk("sticky_set_wins", 10'h2C3, 1'b1);
        clear_chg(10'h2C3);
`endif

        cur = 10'h2C3;
        for (int it = 0; it < 300; it++) begin
            int sel;
            int hold;
            sel = $urandom_range(0, 9);
            if (sel < 4)      cur = W'($urandom);
            else if (sel < 8) cur = cur ^ W'(1 << $urandom_range(0, W - 1));
            bus.SW = cur;
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                bus.chg_ack = ($urandom_range(0, 3) == 0);
                step();
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        bus.chg_ack = 1'b0;
        step(DB + 6);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage that sits directly upstream of the MiniLab switch-to-LED capture logic. It synchronizes the raw board slide switches into the `clk` domain and debounces them as one vector. It then presents a glitch-free stable value plus a change indication. The downstream LED register consumes `sw_stable` instead of raw `SW`.

## Interface
- `WIDTH`, default 10: number of switch bits.
- `DB_CYCLES`, default 1000000: consecutive stable cycles required to commit (20 ms at 50 MHz). Must be ≥2. The bench uses 4.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `SW`, input, WIDTH: raw, asynchronous switch inputs.
- `sw_stable`, output, WIDTH: debounced switch value.
- `sw_chg`, output, 1: change indication (pulse, or sticky with `SW_DEBOUNCE_STICKY_EN`).
- `chg_ack`, input, 1: clears sticky `sw_chg`. Ignored when the sticky feature is compiled out.

## Operation
- **Synchronizer:** two flops per bit, `SW` → `sync1` → `sync2`. Only `sync2` is used downstream.
- **Registers:** `cand` (candidate value, WIDTH bits) and `cnt` ($clog2(DB_CYCLES) bits, unsigned, never wraps).
- **State machine** with two states, IDLE and SETTLE.
  - **IDLE:** holds while `sync2 == cand == sw_stable`.
  - **Any state, `sync2 != cand`:** load `cand <= sync2` and `cnt <= 0`.
    - Next state is IDLE if `sync2 == sw_stable`. This covers a bounce back to the old value, and no change is reported.
    - Otherwise next state is SETTLE.
  - **SETTLE, `sync2 == cand`, `cnt < DB_CYCLES-1`:** `cnt <= cnt+1`.
  - **SETTLE, `sync2 == cand`, `cnt == DB_CYCLES-1`:** commit.
    - `sw_stable <= cand`.
    - `sw_chg` asserts.
    - `cnt <= 0`, next state IDLE.
- **Whole-vector debounce:** any bit changing restarts the count. `sw_stable` never shows a mixed or intermediate vector.
- **Reset values:** `rst` high asynchronously clears `sync1`, `sync2`, `cand`, `cnt`, `sw_stable` and `sw_chg` to 0, and sets state to IDLE.
  - Reset mid-SETTLE discards the pending candidate; no commit occurs for it.
  - After reset, a nonzero `SW` is treated as a change from 0 and is committed normally.

## Timing
- Edge 1 is the first rising edge sampling a new `SW` value.
  - `sync1` updates on edge 1.
  - `sync2` updates on edge 2.
  - `cand` loads and `cnt=0` on edge 3.
  - `cnt` reaches DB_CYCLES-1 on edge DB_CYCLES+2.
  - Commit occurs on edge DB_CYCLES+3.
- **Latency:** DB_CYCLES+3 edges from input change to `sw_stable` update. With DB_CYCLES=4 this is edge 7.
- `sw_stable` and `sw_chg` update on the same edge.
- In pulse mode, `sw_chg` is high for exactly one cycle per commit.
- **Minimum pulse rejected:** any `sync2` disturbance shorter than DB_CYCLES+1 cycles yields no commit.
- All outputs are registered; no combinational path from `SW` or `chg_ack` to any output.

## Configuration
- Feature macro: `SW_DEBOUNCE_STICKY_EN`.
- **Defined:** `sw_chg` sets on commit and holds until a cycle with `chg_ack=1`, then clears on that edge.
  - Commit and `chg_ack` on the same edge: `sw_chg` stays 1 (set wins).
  - `chg_ack` while `sw_chg=0` has no effect.
- **Not defined:** `sw_chg` is a one-cycle pulse per commit and `chg_ack` is unused.

## Test plan
All scenarios use DB_CYCLES=4 and a 10 ns clock.
- **Reset and first commit.**
  - Stimulus: `rst=1` for 10 cycles with `SW=0x155`.
  - Response during reset: `sw_stable=0x000`, `sw_chg=0`.
  - Response after release: `sw_stable=0x155` at edge 7 with a single `sw_chg` pulse.
- **Clean change.**
  - Stimulus: `SW` 0x155→0x234, held.
  - Response: `sw_stable` changes to 0x234 exactly at edge 7 with one `sw_chg` pulse; unchanged at edges 1–6.
- **Bounce.**
  - Stimulus: `SW` alternates 0x234/0x377 every 2 cycles for 20 cycles, then holds 0x377.
  - Response: `sw_stable` stays 0x234 throughout the bouncing, then goes directly to 0x377 with exactly one pulse.
- **Glitch rejection.**
  - Stimulus: with `sw_stable=0x377`, drive `SW=0x000` for 3 cycles, then back to 0x377.
  - Response: no `sw_chg`; `sw_stable` remains 0x377.
- **Reset mid-settle.**
  - Stimulus: change `SW` to 0x0AA, assert `rst` at edge 5.
  - Response: outputs go to 0 immediately (asynchronously), with no pulse before or during reset.
  - After release: commit of 0x0AA at edge 7.
- **Sticky mode (macro defined).**
  - Stimulus: commit 0x155 with no `chg_ack`.
  - Response: `sw_chg` holds 1 for 10 cycles; `chg_ack` clears it on the next edge.
  - A second commit coinciding with `chg_ack` leaves `sw_chg=1`.
